// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light mode scheduler: light codes, FSM states, enb bit map.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package light_pkg;

    typedef enum logic [1:0] {
        RED       = 2'b00,
        YELLOW    = 2'b01,
        GREEN     = 2'b10,
        UNDEFINED = 2'b11
    } light_t;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        PLAN   = 2'd1,
        ONLINE = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam int ENB_W      = 6;
    localparam int ENB_ONLINE = 0;
    localparam int ENB_RST    = 1;
    localparam int ENB_PLAN0  = 5;  // plan p drives bit (ENB_PLAN0 - p)

    // One-hot source select for a given state/plan; FAULT selects nothing.
    function automatic logic [ENB_W-1:0] enb_for(input state_t s, input logic [1:0] plan);
        logic [ENB_W-1:0] e;
        e = '0;
        case (s)
            INIT:    e[ENB_RST] = 1'b1;
            PLAN:    e = (ENB_W'(1) << ENB_PLAN0) >> plan;
            ONLINE:  e[ENB_ONLINE] = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/light_sched_cnt.sv
// Loadable 8-bit down-counter with zero flag; saturates at zero.
// Latency: load/decrement visible one cycle after the request; zero is combinational from the count.
// Backpressure: none; load has priority over dec.
// Ports: clk, rst (sync, active-high), load + load_val, dec, zero.
module light_sched_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/light_mode_sched.sv
// Traffic-light source scheduler: picks reset plan, one of four timing plans, or online control.
// Latency: a decision sampled in cycle N appears on the registered outputs at the end of cycle N.
// Backpressure: none; plan changes wait for a safe boundary (light RED with lightTime 0).
// Ports: clk, rst (sync, active-high); plan_sel/plan_vld, online_req, light, lightTime, fault_clr in;
//        enb (one-hot source select), online_gnt, cur_plan, switch_pending, fault out.
// Optional watchdog (UNDEFINED-light fault detection) is enabled by defining LIGHT_WATCHDOG_EN.
module light_mode_sched
    import light_pkg::*;
#(
    parameter int RST_HOLD    = 16,
    parameter int FAULT_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] plan_sel,
    input  logic       plan_vld,
    input  logic       online_req,
    input  logic [1:0] light,
    input  logic [4:0] lightTime,
    input  logic       fault_clr,
    output logic [5:0] enb,
    output logic       online_gnt,
    output logic [1:0] cur_plan,
    output logic       switch_pending,
    output logic       fault
);

    // The hold counter starts at zero out of reset, so the first INIT cycle only arms it.
    // Loading RST_HOLD-2 then yields exactly RST_HOLD cycles in INIT including the arming cycle.
    localparam logic [7:0] HOLD_LOAD = (RST_HOLD >= 2) ? 8'(RST_HOLD - 2) : 8'd0;

    state_t     state_q, state_d;
    logic [1:0] cur_d, pend_q, pend_d;
    logic       sp_d;
    logic       hold_arm_q, hold_arm_d;
    logic       hold_load, hold_dec, hold_zero, hold_done;
    logic       boundary;
    logic [5:0] enb_d;

    assign boundary = (light == RED) && (lightTime == 5'd0);

    light_sched_cnt u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

`ifdef LIGHT_WATCHDOG_EN
    // Same arming scheme as the hold timer: the first UNDEFINED cycle arms, the
    // FAULT_LIMIT-th consecutive one trips.
    localparam logic [7:0] WD_LOAD = (FAULT_LIMIT >= 2) ? 8'(FAULT_LIMIT - 2) : 8'd0;

    logic wd_arm_q, wd_arm_d;
    logic wd_load, wd_dec, wd_zero, wd_trip;

    light_sched_cnt u_wd_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .dec      (wd_dec),
        .zero     (wd_zero)
    );

    always_comb begin
        wd_arm_d = wd_arm_q;
        wd_load  = 1'b0;
        wd_dec   = 1'b0;
        wd_trip  = 1'b0;
        if (((state_q == PLAN) || (state_q == ONLINE)) && (light == UNDEFINED)) begin
            if (!wd_arm_q) begin
                if (FAULT_LIMIT <= 1) begin
                    wd_trip = 1'b1;
                end else begin
                    wd_load  = 1'b1;
                    wd_arm_d = 1'b1;
                end
            end else if (wd_zero) begin
                wd_trip = 1'b1;
            end else begin
                wd_dec = 1'b1;
            end
        end else begin
            wd_arm_d = 1'b0;
        end
        if (wd_trip) begin
            wd_arm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_arm_q <= 1'b0;
            fault    <= 1'b0;
        end else begin
            wd_arm_q <= wd_arm_d;
            fault    <= (state_d == FAULT);
        end
    end
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr ^ (FAULT_LIMIT == 0);
    assign fault            = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_plan;
        pend_d     = pend_q;
        sp_d       = switch_pending;
        hold_arm_d = hold_arm_q;
        hold_load  = 1'b0;
        hold_dec   = 1'b0;
        hold_done  = 1'b0;

        case (state_q)
            INIT: begin
                if (!hold_arm_q) begin
                    if (RST_HOLD <= 1) begin
                        hold_done = 1'b1;
                    end else begin
                        hold_load  = 1'b1;
                        hold_arm_d = 1'b1;
                    end
                end else if (hold_zero) begin
                    hold_done = 1'b1;
                end else begin
                    hold_dec = 1'b1;
                end
                if (hold_done) begin
                    state_d    = PLAN;
                    cur_d      = switch_pending ? pend_q : 2'd0;
                    sp_d       = 1'b0;
                    hold_arm_d = 1'b0;
                end
            end
            PLAN: begin
                if (boundary) begin
                    if (online_req) begin
                        state_d = ONLINE;  // pending plan is kept for the return to PLAN
                    end else if (switch_pending) begin
                        cur_d = pend_q;
                        sp_d  = 1'b0;
                    end
                end
            end
            ONLINE: begin
                if (boundary && !online_req) begin
                    state_d = PLAN;
                    if (switch_pending) begin
                        cur_d = pend_q;
                        sp_d  = 1'b0;
                    end
                end
            end
`ifdef LIGHT_WATCHDOG_EN
            FAULT: begin
                if (fault_clr) begin
                    state_d    = INIT;
                    hold_arm_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d    = INIT;
                hold_arm_d = 1'b0;
            end
        endcase

`ifdef LIGHT_WATCHDOG_EN
        if (wd_trip) begin
            state_d = FAULT;
        end
`endif

        // A strobe in the same cycle as a boundary becomes pending; the plan applied
        // at that boundary is the one that was already pending.
        if (plan_vld) begin
            pend_d = plan_sel;
            sp_d   = 1'b1;
        end

        enb_d = enb_for(state_d, cur_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= INIT;
            cur_plan       <= 2'd0;
            pend_q         <= 2'd0;
            switch_pending <= 1'b0;
            hold_arm_q     <= 1'b0;
            enb            <= 6'b000010;
            online_gnt     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_plan       <= cur_d;
            pend_q         <= pend_d;
            switch_pending <= sp_d;
            hold_arm_q     <= hold_arm_d;
            enb            <= enb_d;
            online_gnt     <= (state_d == ONLINE);
        end
    end

endmodule
